program_loader: RTL
===================

# program_loader

Sequencing controller for the 16-instruction program memory of the BIP processor. It assembles instruction words from a byte stream (UART receiver), writes them through the program memory write port, holds the CPU in reset while loading, then releases it and waits for the CPU to halt. It sits between the UART receiver, the program memory and the CPU control inputs.

## Interface
- NB_INSTRUCTION, 16, instruction word width
- NB_ADDRESS, 11, program memory address width
- N_INSTRUCTIONS, 16, program memory depth in words
- NB_BYTE, 8, incoming byte width (NB_INSTRUCTION = 2*NB_BYTE)
- TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with LOADER_TIMEOUT_EN
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  load command pulse
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_cpu_halt  in  1  CPU decoded HALT
- o_wr_en  out  1  program memory write strobe
- o_wr_address  out  NB_ADDRESS  write address
- o_wr_data  out  NB_INSTRUCTION  write word
- o_cpu_reset  out  1  holds CPU in reset
- o_cpu_enable  out  1  CPU clock enable
- o_loaded_count  out  NB_ADDRESS  words written in last load
- o_state  out  3  current FSM state (debug/LED)

## Operation
- States: IDLE(0), LOAD(1), START(2), RUN(3), DONE(4).
- IDLE: i_start -> LOAD; word pointer, byte-phase flag and o_loaded_count cleared.
- LOAD: bytes arrive low byte first. First i_rx_valid latches low byte and sets phase flag; second forms {hi, lo}, issues one write at pointer, pointer++, phase flag cleared.
- Load terminates on the write of a HALT word (word[15:11] == 5'b00000) or of the word at address N_INSTRUCTIONS-1; next state START.
- START: one cycle, lets the final write land; -> RUN.
- RUN: o_cpu_reset=0, o_cpu_enable=1; i_cpu_halt -> DONE.
- DONE: o_cpu_enable=0, o_cpu_reset=0 (CPU state observable); i_start -> LOAD.
- i_rx_valid ignored outside LOAD; i_start ignored in LOAD, START, RUN; i_cpu_halt ignored outside RUN.
- o_cpu_reset=1 in IDLE, LOAD, START; o_cpu_enable=0 everywhere but RUN.
- Pointer never wraps: load ends at address N_INSTRUCTIONS-1. Addresses above N_INSTRUCTIONS-1 are never driven.
- o_loaded_count = number of words written, including the HALT word; holds until next LOAD entry.

## Timing
- All outputs registered. Reset values: o_wr_en 0, o_wr_address 0, o_wr_data 0, o_cpu_reset 1, o_cpu_enable 0, o_loaded_count 0, o_state IDLE.
- High byte sampled at cycle n -> o_wr_en=1 with address/data at n+1, single cycle.
- Terminal write at n+1 -> state START at n+1, RUN at n+2 (o_cpu_enable=1 from n+2).
- i_cpu_halt sampled at m in RUN -> DONE, o_cpu_enable=0 at m+1.
- i_reset mid-operation: all registers to reset values next edge; pending low byte discarded; memory contents untouched.
- i_rx_valid on consecutive cycles accepted (full throughput, one byte per cycle).

## Configuration
- LOADER_TIMEOUT_EN defined: counter runs in LOAD while phase flag set or pointer > 0; reloads on each i_rx_valid; reaching TIMEOUT_CYCLES -> IDLE, partial byte discarded, o_loaded_count keeps words already written.
- Undefined: no counter, LOAD waits indefinitely; TIMEOUT_CYCLES unused.

## Structure
- Package program_loader_pkg: state encodings, HALT opcode constant (5'b00000), opcode field position [15:11].
- One sub-module: loader_timeout_counter (load/enable, terminal-count pulse), instantiated only under LOADER_TIMEOUT_EN.

## Test plan
- Reset then idle: outputs at reset values, o_cpu_reset=1, o_state=0 for 10 cycles with random i_rx_valid.
- i_start; bytes 0x01,0x08,0x02,0x10,0x00,0x00 -> writes (0,0x0801),(1,0x1002),(2,0x0000); START then RUN two cycles after last write; o_loaded_count=3.
- 32 bytes, no HALT word (all 0x08xx) -> 16 writes, addresses 0..15, RUN entered, 33rd byte produces no write.
- In RUN, pulse i_cpu_halt -> DONE next cycle, o_cpu_enable=0; i_start -> LOAD, o_loaded_count=0, pointer restarts at 0.
- i_reset asserted after one low byte -> IDLE, no write; new load writes address 0 with correct pairing.
- With LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=50: one byte then silence -> IDLE at cycle 50 after last byte, no write issued.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the BIP program loader: widths, FSM state encoding and
// the HALT opcode decode.
package program_loader_pkg;

  localparam int NB_INSTRUCTION = 16;
  localparam int NB_ADDRESS     = 11;
  localparam int N_INSTRUCTIONS = 16;
  localparam int NB_BYTE        = 8;

  localparam int NB_OPCODE  = 5;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;
  localparam logic [NB_OPCODE-1:0] HALT_OPCODE = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_halt(input logic [NB_INSTRUCTION-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream, program-memory write port and CPU control signals of the loader.
// The slave modport is the loader itself; master is whoever drives it.
interface program_loader_if;
  import program_loader_pkg::*;

  logic                      i_start;
  logic [NB_BYTE-1:0]        i_rx_data;
  logic                      i_rx_valid;
  logic                      i_cpu_halt;
  logic                      o_wr_en;
  logic [NB_ADDRESS-1:0]     o_wr_address;
  logic [NB_INSTRUCTION-1:0] o_wr_data;
  logic                      o_cpu_reset;
  logic                      o_cpu_enable;
  logic [NB_ADDRESS-1:0]     o_loaded_count;
  logic [2:0]                o_state;

  modport master (
    output i_start, i_rx_data, i_rx_valid, i_cpu_halt,
    input  o_wr_en, o_wr_address, o_wr_data, o_cpu_reset, o_cpu_enable,
           o_loaded_count, o_state
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_valid, i_cpu_halt,
    output o_wr_en, o_wr_address, o_wr_data, o_cpu_reset, o_cpu_enable,
           o_loaded_count, o_state
  );

endinterface

// File: rtl/loader_timeout_counter.sv
// Inter-byte watchdog for the loader; only built when LOADER_TIMEOUT_EN is defined.
// o_expired pulses in the cycle before the TIMEOUT_CYCLES-th idle edge.
`ifdef LOADER_TIMEOUT_EN
module loader_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_load) begin
      count_q <= '0;
    end else if (i_enable) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign o_expired = i_enable && !i_load && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/program_loader.sv
// program_loader: pairs UART bytes into instruction words, writes them to program memory,
// then runs the BIP CPU until HALT. LOADER_TIMEOUT_EN enables the inter-byte timeout.
module program_loader
  import program_loader_pkg::*;
`ifdef LOADER_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 1000000)
`endif
(
  input logic             i_clock,
  input logic             i_reset,
  program_loader_if.slave bus
);

  state_t                    state_q, state_d;
  logic [NB_ADDRESS-1:0]     pointer_q, pointer_d;
  logic                      phase_q, phase_d;
  logic [NB_BYTE-1:0]        lo_q, lo_d;
  logic                      wr_en_q, wr_en_d;
  logic [NB_ADDRESS-1:0]     wr_address_q, wr_address_d;
  logic [NB_INSTRUCTION-1:0] wr_data_q, wr_data_d;
  logic [NB_ADDRESS-1:0]     loaded_count_q, loaded_count_d;
  logic                      cpu_reset_q, cpu_reset_d;
  logic                      cpu_enable_q, cpu_enable_d;
  logic [NB_INSTRUCTION-1:0] word;
  logic                      timeout_hit;

`ifdef LOADER_TIMEOUT_EN
  logic timeout_enable;
  assign timeout_enable = (state_q == ST_LOAD) && (phase_q || (pointer_q != '0));

  loader_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (bus.i_rx_valid || !timeout_enable),
    .i_enable (timeout_enable),
    .o_expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign word = {bus.i_rx_data, lo_q};

  // The terminal write and the move to START share one edge, so START always
  // lasts exactly the cycle in which that last write reaches memory.
  always_comb begin
    state_d        = state_q;
    pointer_d      = pointer_q;
    phase_d        = phase_q;
    lo_d           = lo_q;
    wr_en_d        = 1'b0;
    wr_address_d   = wr_address_q;
    wr_data_d      = wr_data_q;
    loaded_count_d = loaded_count_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          state_d        = ST_LOAD;
          pointer_d      = '0;
          phase_d        = 1'b0;
          loaded_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (bus.i_rx_valid) begin
          if (!phase_q) begin
            lo_d    = bus.i_rx_data;
            phase_d = 1'b1;
          end else begin
            wr_en_d        = 1'b1;
            wr_address_d   = pointer_q;
            wr_data_d      = word;
            pointer_d      = pointer_q + NB_ADDRESS'(1);
            loaded_count_d = pointer_q + NB_ADDRESS'(1);
            phase_d        = 1'b0;
            if (is_halt(word) || (pointer_q == NB_ADDRESS'(N_INSTRUCTIONS - 1))) begin
              state_d = ST_START;
            end
          end
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          phase_d = 1'b0;
        end
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.i_cpu_halt) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cpu_reset_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_START);
    cpu_enable_d = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      pointer_q      <= '0;
      phase_q        <= 1'b0;
      lo_q           <= '0;
      wr_en_q        <= 1'b0;
      wr_address_q   <= '0;
      wr_data_q      <= '0;
      loaded_count_q <= '0;
      cpu_reset_q    <= 1'b1;
      cpu_enable_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pointer_q      <= pointer_d;
      phase_q        <= phase_d;
      lo_q           <= lo_d;
      wr_en_q        <= wr_en_d;
      wr_address_q   <= wr_address_d;
      wr_data_q      <= wr_data_d;
      loaded_count_q <= loaded_count_d;
      cpu_reset_q    <= cpu_reset_d;
      cpu_enable_q   <= cpu_enable_d;
    end
  end

  assign bus.o_wr_en        = wr_en_q;
  assign bus.o_wr_address   = wr_address_q;
  assign bus.o_wr_data      = wr_data_q;
  assign bus.o_loaded_count = loaded_count_q;
  assign bus.o_cpu_reset    = cpu_reset_q;
  assign bus.o_cpu_enable   = cpu_enable_q;
  assign bus.o_state        = state_q;

endmodule
